seq_pattern_gen: RTL and testbench

Serial bit-pattern transmitter: on a start request it emits a loaded pattern of 1..PAT_W bits, MSB-first, one bit per clock, with a valid qualifier. It repeats the pattern a programmed number of times, with an optional idle gap between repetitions. It drives the serial input of the team's FSM sequence detectors, for example a 101 detector, for in-system self-test and as a reusable serial stimulus source.

---
 rtl/seq_pattern_gen_if.sv | 29 ++
 rtl/seq_pattern_gen.sv | 169 ++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_gen_if.sv
// rtl/seq_pattern_gen_if.sv - control, config and serial output bundle for seq_pattern_gen
interface seq_pattern_gen_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pat_i;
  logic [LEN_W-1:0] len_i;
  logic [CNT_W-1:0] rep_i;
  logic [GAP_W-1:0] gap_i;
  logic             ser_o;
  logic             ser_vld;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, abort, pat_i, len_i, rep_i, gap_i,
    input  ser_o, ser_vld, busy, done, err
  );

  modport slave (
    input  start, abort, pat_i, len_i, rep_i, gap_i,
    output ser_o, ser_vld, busy, done, err
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - serial MSB-first pattern transmitter with repeat count and idle gap
module seq_pattern_gen #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  seq_pattern_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic             ser_q, ser_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             cfg_ok;
  logic             first_in_bit;
  logic             first_reg_bit;
  logic             next_reg_bit;

  // Masked reduction rather than a variable bit-select so every pattern bit is consumed
  function automatic logic pick(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] i);
    return |(p & (PAT_W'(1) << i));
  endfunction

  assign cfg_ok        = (bus.len_i != '0) && (bus.len_i <= LEN_MAX) && (bus.rep_i != '0);
  assign first_in_bit  = pick(bus.pat_i, bus.len_i - LEN_W'(1));
  assign first_reg_bit = pick(pat_q, len_q - LEN_W'(1));
  assign next_reg_bit  = pick(pat_q, idx_q - LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      reps_q  <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      ser_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      reps_q  <= reps_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      ser_q   <= ser_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    reps_d  = reps_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    ser_d   = 1'b0;
    vld_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (cfg_ok) begin
            pat_d   = bus.pat_i;
            len_d   = bus.len_i;
            reps_d  = bus.rep_i;
            gap_d   = bus.gap_i;
            idx_d   = bus.len_i - LEN_W'(1);
            ser_d   = first_in_bit;
            vld_d   = 1'b1;
            busy_d  = 1'b1;
            state_d = SHIFT;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      SHIFT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (idx_q == '0) begin
          if (reps_q > CNT_W'(1)) begin
            if (gap_q == '0) begin
              reps_d = reps_q - CNT_W'(1);
              idx_d  = len_q - LEN_W'(1);
              ser_d  = first_reg_bit;
              vld_d  = 1'b1;
              busy_d = 1'b1;
            end else begin
              gcnt_d  = gap_q;
              busy_d  = 1'b1;
              state_d = GAP;
            end
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          idx_d  = idx_q - LEN_W'(1);
          ser_d  = next_reg_bit;
          vld_d  = 1'b1;
          busy_d = 1'b1;
        end
      end

      GAP: begin
        // gcnt counts the gap cycles still to be shown including the current one
        if (bus.abort) begin
          state_d = IDLE;
        end else if (gcnt_q == GAP_W'(1)) begin
          reps_d  = reps_q - CNT_W'(1);
          idx_d   = len_q - LEN_W'(1);
          ser_d   = first_reg_bit;
          vld_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          gcnt_d = gcnt_q - GAP_W'(1);
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ser_o   = ser_q;
  assign bus.ser_vld = vld_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - scoreboard bench for seq_pattern_gen
module tb_seq_pattern_gen;
  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 4;
  localparam int GAP_W = 4;

  typedef struct packed {
    logic vld;
    logic ser;
    logic busy;
    logic done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         errors = 0;
  int         checks = 0;
  int         det_cnt = 0;
  int         busy_cnt = 0;
  logic [2:0] hist = '0;
  exp_t       sb[$];

  seq_pattern_gen_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

  seq_pattern_gen #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " ser_o"},   32'(bus.ser_o),   32'd0);
    chk({tag, " ser_vld"}, 32'(bus.ser_vld), 32'd0);
    chk({tag, " busy"},    32'(bus.busy),    32'd0);
    chk({tag, " done"},    32'(bus.done),    32'd0);
    chk({tag, " err"},     32'(bus.err),     32'd0);
  endtask

  // Called at a negedge; leaves the bench at a negedge.
  task automatic tx(input string tag, input logic [7:0] pat, input int len, input int rep,
                    input int gap, input int poke_at, input int abort_at, input int rst_at);
    exp_t e;
    int   i;
    bit   stop;
    sb.delete();
    for (int r = 0; r < rep; r++) begin
      for (int b = len - 1; b >= 0; b--) sb.push_back(exp_t'{1'b1, pat[b], 1'b1, 1'b0});
      if (r < rep - 1) for (int g = 0; g < gap; g++) sb.push_back(exp_t'{1'b0, 1'b0, 1'b1, 1'b0});
    end
    sb.push_back(exp_t'{1'b0, 1'b0, 1'b0, 1'b1});
    sb.push_back(exp_t'{1'b0, 1'b0, 1'b0, 1'b0});
    if (abort_at >= 0) begin
      while (sb.size() > abort_at + 1) void'(sb.pop_back());
      repeat (3) sb.push_back(exp_t'{1'b0, 1'b0, 1'b0, 1'b0});
    end

    det_cnt  = 0;
    hist     = '0;
    busy_cnt = 0;
    bus.pat_i = pat;
    bus.len_i = 4'(len);
    bus.rep_i = 4'(rep);
    bus.gap_i = 4'(gap);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.pat_i = ~pat;
    bus.len_i = '0;
    bus.rep_i = '0;
    bus.gap_i = 4'hF;

    i = 0;
    stop = 1'b0;
    while (sb.size() > 0 && !stop) begin
      e = sb.pop_front();
      chk({tag, " ser_vld"}, 32'(bus.ser_vld), 32'(e.vld));
      chk({tag, " ser_o"},   32'(bus.ser_o),   32'(e.ser));
      chk({tag, " busy"},    32'(bus.busy),    32'(e.busy));
      chk({tag, " done"},    32'(bus.done),    32'(e.done));
      chk({tag, " err"},     32'(bus.err),     32'd0);
      if (bus.busy) busy_cnt++;
      if (bus.ser_vld) begin
        hist = {hist[1:0], bus.ser_o};
        if (hist == 3'b101) det_cnt++;
      end
      bus.start = (i == poke_at);
      if (i == poke_at) bus.pat_i = 8'h3C;
      bus.abort = (i == abort_at);
      if (i == rst_at) begin
        #2 rst = 1'b1;
        #1 chk_idle({tag, " async_rst"});
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
        stop = 1'b1;
      end else begin
        @(negedge clk);
      end
      i++;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    if (abort_at < 0 && rst_at < 0)
      chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(rep * len + (rep - 1) * gap));
  endtask

  task automatic reject(input string tag, input int len, input int rep);
    bus.pat_i = 8'hFF;
    bus.len_i = 4'(len);
    bus.rep_i = 4'(rep);
    bus.gap_i = '0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, " err"},     32'(bus.err),     32'd1);
    chk({tag, " busy"},    32'(bus.busy),    32'd0);
    chk({tag, " ser_vld"}, 32'(bus.ser_vld), 32'd0);
    @(negedge clk);
    chk_idle({tag, " after"});
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.pat_i = '0;
    bus.len_i = '0;
    bus.rep_i = '0;
    bus.gap_i = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    tx("basic", 8'h05, 3, 1, 0, -1, -1, -1);
    chk("basic det101", 32'(det_cnt), 32'd1);

    tx("rep_gap", 8'h05, 3, 2, 2, -1, -1, -1);
    tx("b2b", 8'hA5, 8, 2, 0, -1, -1, -1);

    reject("len0", 0, 1);
    reject("len9", 9, 1);
    reject("rep0", 3, 0);

    tx("busy_start", 8'hA5, 8, 1, 0, 2, -1, -1);
    tx("abort", 8'hA5, 8, 1, 0, -1, 3, -1);
    tx("abort_gap", 8'h05, 3, 2, 4, -1, 4, -1);
    tx("rst_gap", 8'h05, 3, 2, 3, -1, -1, 4);
    tx("post_rst", 8'hB3, 7, 3, 1, -1, -1, -1);
    tx("len1", 8'h81, 1, 3, 0, -1, -1, -1);
    tx("max", 8'h96, 8, 2, 15, -1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
